// File: rtl/rom_addr_seq_if.sv
// Signal bundle between the ROM address sequencer and its surroundings:
// serial instruction in, carry/key status in, sync/serial address/debug out.
interface rom_addr_seq_if;
    logic       is;      // serial instruction bit, LSB first, T45..T54
    logic       carry;   // datapath carry, any state
    logic       kflag;   // key-down flag
    logic [5:0] kcode;   // latched key code
    logic       sync;    // instruction window marker
    logic       ia;      // serial next-address bit, LSB first, T19..T26
    logic [7:0] adr;     // current ROM address
    logic [9:0] inst;    // last decoded instruction

    // Environment side: drives the serial/status inputs, observes outputs
    modport master (
        output is, carry, kflag, kcode,
        input  sync, ia, adr, inst
    );

    // Sequencer side
    modport slave (
        input  is, carry, kflag, kcode,
        output sync, ia, adr, inst
    );
endinterface

// File: rtl/rom_addr_seq.sv
// ROM address sequencer: word-time counter, serial instruction capture,
// next-address decode (sequential / JSB / RETURN / carry branch / key jump),
// return stack and serial address output.
//
// Optional build macro ROM_RTN_STACK2_EN: when defined the return stack is
// two levels deep (push shifts top into lower, pop copies lower into top and
// leaves lower duplicated). Undefined builds a single-level stack only.
module rom_addr_seq #(
    parameter int WORD_LEN = 56,
    parameter int IA_T0    = 19
) (
    input  logic          cph2,
    input  logic          nrst,
    rom_addr_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_LEN);
    // Instruction window is the 10 states just before the last state.
    localparam int IS_T0 = WORD_LEN - 11;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WORD_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(IS_T0);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(IS_T0 + 9);

    localparam logic [9:0] INST_RET  = 10'h030;
    localparam logic [9:0] INST_KEYJ = 10'h0D0;

    // Source of the next address chosen at the end of a word
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_RET,
        SEL_KEY,
        SEL_JSB,
        SEL_BR
    } adr_sel_t;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       ibuf_reg, ibuf_next;
    logic [9:0]       inst_reg, inst_next;
    logic [7:0]       adr_reg, adr_next;
    logic [7:0]       stk_top_reg, stk_top_next;
`ifdef ROM_RTN_STACK2_EN
    logic [7:0]       stk_low_reg, stk_low_next;
`endif
    logic             cf_reg, cf_next;
    logic             cq_reg, cq_next;

    logic             word_end;
    logic [7:0]       adr_inc;
    logic [9:0]       cap_en;
    logic [7:0]       ia_hit;
    adr_sel_t         adr_sel;

    assign word_end = (cnt_reg == LAST_CNT);
    assign adr_inc  = adr_reg + 8'd1;

    // One capture strobe per instruction bit, bit i taken in state IS_T0+i
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_cap
            localparam logic [CNT_W-1:0] CAP_SLOT = CNT_W'(IS_T0 + gi);
            assign cap_en[gi] = (cnt_reg == CAP_SLOT);
        end
    endgenerate

    // Serial address: address bit i is presented during state IA_T0+i
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ia
            localparam logic [CNT_W-1:0] IA_SLOT = CNT_W'(IA_T0 + gi);
            assign ia_hit[gi] = (cnt_reg == IA_SLOT) & adr_reg[gi];
        end
    endgenerate

    assign bus.ia   = |ia_hit;
    assign bus.sync = (cnt_reg >= SYNC_FIRST) && (cnt_reg <= SYNC_LAST);
    assign bus.adr  = adr_reg;
    assign bus.inst = inst_reg;

    // Word counter, instruction shift-in and carry accumulation
    always_comb begin
        cnt_next  = word_end ? '0 : cnt_reg + CNT_W'(1);
        ibuf_next = ibuf_reg;
        for (int i = 0; i < 10; i++) begin
            if (cap_en[i]) begin
                ibuf_next[i] = bus.is;
            end
        end
        inst_next = word_end ? ibuf_reg : inst_reg;
        // A carry in the last state still belongs to this word.
        cf_next   = word_end ? 1'b0 : (cf_reg | bus.carry);
        cq_next   = word_end ? (cf_reg | bus.carry) : cq_reg;
    end

    // Classify the just-received instruction; branch uses last word's carry
    always_comb begin
        adr_sel = SEL_SEQ;
        if (ibuf_reg == INST_RET) begin
            adr_sel = SEL_RET;
        end else if (ibuf_reg == INST_KEYJ) begin
            adr_sel = bus.kflag ? SEL_KEY : SEL_SEQ;
        end else if (ibuf_reg[1:0] == 2'b01) begin
            adr_sel = SEL_JSB;
        end else if (ibuf_reg[1:0] == 2'b11) begin
            adr_sel = cq_reg ? SEL_SEQ : SEL_BR;
        end
    end

    // Program counter and return stack update, only on the last state
    always_comb begin
        adr_next     = adr_reg;
        stk_top_next = stk_top_reg;
`ifdef ROM_RTN_STACK2_EN
        stk_low_next = stk_low_reg;
`endif
        if (word_end) begin
            case (adr_sel)
                SEL_RET: begin
                    adr_next = stk_top_reg;
`ifdef ROM_RTN_STACK2_EN
                    stk_top_next = stk_low_reg;
`endif
                end
                SEL_KEY: begin
                    adr_next = {2'b00, bus.kcode};
                end
                SEL_JSB: begin
                    adr_next     = ibuf_reg[9:2];
                    stk_top_next = adr_inc;
`ifdef ROM_RTN_STACK2_EN
                    stk_low_next = stk_top_reg;
`endif
                end
                SEL_BR: begin
                    adr_next = ibuf_reg[9:2];
                end
                default: begin
                    adr_next = adr_inc;
                end
            endcase
        end
    end

    // State registers; reset discards any partially received instruction
    always_ff @(posedge cph2 or negedge nrst) begin
        if (!nrst) begin
            cnt_reg     <= '0;
            ibuf_reg    <= '0;
            inst_reg    <= '0;
            adr_reg     <= '0;
            stk_top_reg <= '0;
`ifdef ROM_RTN_STACK2_EN
            stk_low_reg <= '0;
`endif
            cf_reg      <= 1'b0;
            cq_reg      <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            ibuf_reg    <= ibuf_next;
            inst_reg    <= inst_next;
            adr_reg     <= adr_next;
            stk_top_reg <= stk_top_next;
`ifdef ROM_RTN_STACK2_EN
            stk_low_reg <= stk_low_next;
`endif
            cf_reg      <= cf_next;
            cq_reg      <= cq_next;
        end
    end
endmodule

// File: tb/tb_rom_addr_seq.sv
// Bench for rom_addr_seq: word-level model of the sequencer (address,
// instruction, return stack as a queue) checked against the DUT every cycle,
// plus literal address expectations after each directed word.
module tb_rom_addr_seq;
    logic cph2 = 1'b0;
    logic nrst = 1'b0;

    rom_addr_seq_if bus ();

    rom_addr_seq #(.WORD_LEN(56), .IA_T0(19)) dut (
        .cph2 (cph2),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 cph2 = ~cph2;

`ifdef ROM_RTN_STACK2_EN
    localparam int STK_DEPTH = 2;
`else
    localparam int STK_DEPTH = 1;
`endif

    int         tests = 0;
    int         fails = 0;
    int         phase = 0;
    bit         active = 1'b0;
    logic [7:0] exp_adr = 8'h00;
    logic [9:0] exp_inst = 10'h000;
    bit         prev_carry = 1'b0;
    logic [7:0] ia_cap = 8'h00;
    logic [7:0] rstk[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        exp_adr    = 8'h00;
        exp_inst   = 10'h000;
        prev_carry = 1'b0;
        rstk.delete();
        for (int i = 0; i < STK_DEPTH; i++) rstk.push_back(8'h00);
    endtask

    // Per-cycle comparison against the word-level model
    always @(negedge cph2) begin
        if (active) begin
            chk($sformatf("adr@T%0d", phase), {24'h0, bus.adr}, {24'h0, exp_adr});
            chk($sformatf("inst@T%0d", phase), {22'h0, bus.inst}, {22'h0, exp_inst});
            chk($sformatf("sync@T%0d", phase), {31'h0, bus.sync},
                {31'h0, (phase >= 45 && phase <= 54)});
            if (phase >= 19 && phase <= 26) begin
                chk($sformatf("ia@T%0d", phase), {31'h0, bus.ia}, {31'h0, exp_adr[phase-19]});
                ia_cap[phase-19] = bus.ia;
            end else begin
                chk($sformatf("ia_idle@T%0d", phase), {31'h0, bus.ia}, 32'h0);
            end
        end
    end

    task automatic drive_state(input int t, input logic [9:0] instr, input int carry_t,
                               input bit kf, input logic [5:0] kc);
        phase     = t;
        bus.is    = (t >= 45 && t <= 54) ? instr[t-45] : t[0];
        bus.carry = (t == carry_t);
        bus.kflag = (t == 55) ? kf : ~kf;
        bus.kcode = (t == 55) ? kc : ~kc;
    endtask

    // Send one full word and advance the model by one instruction
    task automatic run_word(input logic [9:0] instr, input int carry_t,
                            input bit kf, input logic [5:0] kc);
        logic [7:0] top;
        for (int t = 0; t < 56; t++) begin
            drive_state(t, instr, carry_t, kf, kc);
            @(posedge cph2);
            #1;
        end
        if (instr == 10'h030) begin
            top = rstk[0];
            exp_adr = top;
            if (rstk.size() > 1) begin
                void'(rstk.pop_front());
                rstk.push_back(rstk[rstk.size()-1]);
            end
        end else if (instr == 10'h0D0) begin
            exp_adr = kf ? {2'b00, kc} : exp_adr + 8'd1;
        end else if (instr[1:0] == 2'b01) begin
            rstk.push_front(exp_adr + 8'd1);
            void'(rstk.pop_back());
            exp_adr = instr[9:2];
        end else if (instr[1:0] == 2'b11) begin
            exp_adr = prev_carry ? exp_adr + 8'd1 : instr[9:2];
        end else begin
            exp_adr = exp_adr + 8'd1;
        end
        prev_carry = (carry_t >= 0 && carry_t < 56);
        exp_inst   = instr;
        phase      = 0;
    endtask

    task automatic step(input string name, input logic [9:0] instr, input int carry_t,
                        input bit kf, input logic [5:0] kc, input logic [7:0] want);
        run_word(instr, carry_t, kf, kc);
        chk({name, "_dut"}, {24'h0, bus.adr}, {24'h0, want});
        chk({name, "_model"}, {24'h0, exp_adr}, {24'h0, want});
        $display("[TB] word %s inst=%03h -> adr=%02h (want %02h)", name, instr, bus.adr, want);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_adr"}, {24'h0, bus.adr}, 32'h0);
        chk({name, "_inst"}, {22'h0, bus.inst}, 32'h0);
        chk({name, "_sync"}, {31'h0, bus.sync}, 32'h0);
        chk({name, "_ia"}, {31'h0, bus.ia}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.is = 1'b0; bus.carry = 1'b0; bus.kflag = 1'b0; bus.kcode = 6'h00;
        model_reset();
        repeat (3) @(posedge cph2);
        #1;
        chk_reset_outputs("por");
        @(posedge cph2);
        #1;
        nrst   = 1'b1;
        active = 1'b1;

        step("idle0", 10'h000, -1, 1'b0, 6'h00, 8'h01);
        step("idle1", 10'h000, -1, 1'b0, 6'h00, 8'h02);
        chk("ia_word2", {24'h0, ia_cap}, 32'h01);
        step("br_ff", 10'h3FF, -1, 1'b0, 6'h00, 8'hFF);
        step("wrap", 10'h000, -1, 1'b0, 6'h00, 8'h00);
        step("br_10", 10'h043, -1, 1'b0, 6'h00, 8'h10);
        step("jsb40", 10'h101, -1, 1'b0, 6'h00, 8'h40);
        step("ret11", 10'h030, -1, 1'b0, 6'h00, 8'h11);
        step("carry30", 10'h000, 30, 1'b0, 6'h00, 8'h12);
        step("br_cq1", 10'h08B, -1, 1'b0, 6'h00, 8'h13);
        step("nop14", 10'h000, -1, 1'b0, 6'h00, 8'h14);
        step("br_t55", 10'h08B, 55, 1'b0, 6'h00, 8'h22);
        step("br_prev55", 10'h08B, -1, 1'b0, 6'h00, 8'h23);
        step("keyj1", 10'h0D0, -1, 1'b1, 6'h2A, 8'h2A);
        step("keyj0", 10'h0D0, -1, 1'b0, 6'h2A, 8'h2B);
        step("br_05", 10'h017, -1, 1'b0, 6'h00, 8'h05);
        step("jsb41", 10'h105, -1, 1'b0, 6'h00, 8'h41);
        step("jsb80", 10'h201, -1, 1'b0, 6'h00, 8'h80);
        step("ret1", 10'h030, -1, 1'b0, 6'h00, 8'h42);
`ifdef ROM_RTN_STACK2_EN
        step("ret2", 10'h030, -1, 1'b0, 6'h00, 8'h06);
        step("ret3", 10'h030, -1, 1'b0, 6'h00, 8'h06);
`else
        step("ret2", 10'h030, -1, 1'b0, 6'h00, 8'h42);
        step("ret3", 10'h030, -1, 1'b0, 6'h00, 8'h42);
`endif

        // Abort a JSB mid-instruction with reset at T50
        for (int t = 0; t < 50; t++) begin
            drive_state(t, 10'h101, -1, 1'b0, 6'h00);
            @(posedge cph2);
            #1;
        end
        drive_state(50, 10'h101, -1, 1'b0, 6'h00);
        active = 1'b0;
        nrst   = 1'b0;
        #1;
        chk_reset_outputs("rst_t50");
        repeat (2) @(posedge cph2);
        #1;
        chk_reset_outputs("rst_hold");
        nrst = 1'b1;
        model_reset();
        phase  = 0;
        active = 1'b1;
        chk("rst_release_adr", {24'h0, bus.adr}, 32'h0);
        $display("[TB] reset at T50 -> adr=%02h inst=%03h", bus.adr, bus.inst);
        step("post_rst", 10'h000, -1, 1'b0, 6'h00, 8'h01);
        step("ret_clr", 10'h030, -1, 1'b0, 6'h00, 8'h00);

        active = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
